// File: rtl/traf_pkg.sv
// Shared definitions for the traffic-light phase controller: one-hot phase
// encodings, lamp codes and the countdown-timer load constants.
package traf_pkg;

    // One-hot phase encoding; the name refers to the NS lamp in that phase
    typedef enum logic [3:0] {
        ST0 = 4'b0001,   // NS red, EW green/yellow
        ST1 = 4'b0010,   // NS green
        ST2 = 4'b0100,   // NS yellow
        ST3 = 4'b1000    // all red, optional pedestrian walk
    } state_t;

    // Lamp codes, bit order {R,Y,G}
    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    // Countdown timer load values for each phase
    localparam logic [7:0] LOAD_ST0 = 8'd59;
    localparam logic [7:0] LOAD_ST1 = 8'd54;
    localparam logic [7:0] LOAD_ST2 = 8'd4;
    localparam logic [7:0] LOAD_ST3 = 8'd0;

    // Load value the timer picks up for a given phase; anything that is not
    // a legal phase is treated like the all-red phase.
    function automatic logic [7:0] loadValue(input logic [3:0] st);
        logic [7:0] val;
        case (st)
            ST0:     val = LOAD_ST0;
            ST1:     val = LOAD_ST1;
            ST2:     val = LOAD_ST2;
            default: val = LOAD_ST3;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/traf_fsm_if.sv
// Signal bundle between the phase controller and the countdown timer /
// lamp drivers. The controller side uses the master modport.
interface traf_fsm_if;
    import traf_pkg::*;

    logic       Done_NS;
    logic [7:0] Q_NS;
    logic       Ped_req;
    logic       Ld;
    logic       En;
    logic [3:0] State;
    logic [2:0] Lamp_NS;
    logic [2:0] Lamp_EW;
    logic       Walk;

    modport master (
        input  Done_NS, Q_NS, Ped_req,
        output Ld, En, State, Lamp_NS, Lamp_EW, Walk
    );

    modport slave (
        output Done_NS, Q_NS, Ped_req,
        input  Ld, En, State, Lamp_NS, Lamp_EW, Walk
    );

endinterface

// File: rtl/tick_gen.sv
// Free-running tick divider: raises Tick for one clock every TICK_DIV clocks.
// Clr restarts the period so that a new phase always begins with a full tick.
module tick_gen #(
    parameter int TICK_DIV = 50000000
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic Clr,
    output logic Tick
);

    localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: wrap at the end of the period, restart whenever cleared
    always_comb begin
        count_d = count_q + CW'(1);
        if (Clr || (count_q == LAST)) begin
            count_d = '0;
        end
    end

    // Period counter
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign Tick = (count_q == LAST);

endmodule

// File: rtl/traf_fsm.sv
// Traffic-light phase controller. Sequences St1 -> St2 -> St0 -> St3 -> St1,
// strobes the countdown timer load on every phase entry, produces the timer
// tick enable, decodes the NS/EW lamps and adds a latched pedestrian walk
// extension to the all-red phase.
module traf_fsm
    import traf_pkg::*;
#(
    parameter int         TICK_DIV   = 50000000,
    parameter int         WALK_TICKS = 8,
    parameter logic [7:0] EW_YEL     = 8'h04
) (
    input  logic       Clk,
    input  logic       Reset_n,
    traf_fsm_if.master bus
);

    localparam int             WCW       = $clog2(WALK_TICKS + 1);
    localparam logic [WCW-1:0] WALK_LAST = WCW'(WALK_TICKS - 1);

    state_t         state_q;
    logic           ld_q;
    logic           pedLat_q;
    logic           walkAct_q;
    logic [WCW-1:0] walkCnt_q;

    logic           tick;
    logic           en;
    logic [2:0]     lampNs;
    logic [2:0]     lampEw;
    logic           walkLamp;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) uTickGen (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .Clr     (ld_q),
        .Tick    (tick)
    );

    // The load cycle never carries a tick, so each phase starts on a fresh period
    assign en = tick & ~ld_q;

    // Phase sequencing, load strobe, pedestrian latch and walk timing
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= ST1;
            ld_q      <= 1'b0;
            pedLat_q  <= 1'b0;
            walkAct_q <= 1'b0;
            walkCnt_q <= '0;
        end else begin
            ld_q <= 1'b0;
            if (bus.Ped_req) begin
                pedLat_q <= 1'b1;
            end
            case (state_q)
                ST1: begin
                    if (bus.Done_NS) begin
                        state_q <= ST2;
                        ld_q    <= 1'b1;
                    end
                end
                ST2: begin
                    if (bus.Done_NS) begin
                        state_q <= ST0;
                        ld_q    <= 1'b1;
                    end
                end
                ST0: begin
                    if (bus.Done_NS) begin
                        state_q   <= ST3;
                        ld_q      <= 1'b1;
                        walkAct_q <= pedLat_q;
                        pedLat_q  <= bus.Ped_req;
                        walkCnt_q <= '0;
                    end
                end
                ST3: begin
                    if (walkAct_q) begin
                        if (en) begin
                            walkCnt_q <= walkCnt_q + WCW'(1);
                            if (walkCnt_q == WALK_LAST) begin
                                state_q   <= ST1;
                                ld_q      <= 1'b1;
                                walkAct_q <= 1'b0;
                            end
                        end
                    end else if (bus.Done_NS) begin
                        state_q <= ST1;
                        ld_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= ST3;
                    ld_q      <= 1'b1;
                    walkAct_q <= 1'b0;
                    walkCnt_q <= '0;
                end
            endcase
        end
    end

    // Lamp decode from the phase register and the live timer count
    always_comb begin
        lampNs   = LAMP_RED;
        lampEw   = LAMP_RED;
        walkLamp = 1'b0;
        case (state_q)
            ST1: lampNs = LAMP_GRN;
            ST2: lampNs = LAMP_YEL;
            ST0: lampEw = (bus.Q_NS > EW_YEL) ? LAMP_GRN : LAMP_YEL;
            ST3: walkLamp = walkAct_q;
            default: ;
        endcase
    end

    assign bus.State   = state_q;
    assign bus.Ld      = ld_q;
    assign bus.En      = en;
    assign bus.Lamp_NS = lampNs;
    assign bus.Lamp_EW = lampEw;
    assign bus.Walk    = walkLamp;

endmodule

// File: doc/traf_fsm.md
# traf_fsm

Phase controller for the traffic-light signal path. It sequences the four one-hot phases, drives the countdown timer's `Ld`, `En` and `State` inputs, and consumes the timer's `Done_NS` and `Q_NS` outputs. It decodes NS/EW lamp outputs and adds a latched pedestrian walk extension. It sits between the board-level tick source (system clock) and the per-direction countdown timers.

## Interface
Parameters:
- `TICK_DIV`, default 50000000: system clocks per timer tick; must be ≥ 2.
- `WALK_TICKS`, default 8: ticks the walk phase lasts; must be ≥ 1.
- `EW_YEL`, default 8'h04: EW shows yellow while `Q_NS` ≤ this value in St0.

Ports:
- `Clk` in 1: system clock, rising edge.
- `Reset_n` in 1: asynchronous, active-low reset.
- `Done_NS` in 1: timer expired (`Q_NS`==0 and `En`).
- `Q_NS` in 8: timer count.
- `Ped_req` in 1: pedestrian request, level, synchronous to `Clk`.
- `Ld` out 1: timer load strobe; the timer loads the value selected by `State`.
- `En` out 1: one-clock tick pulse to the timer(s).
- `State` out 4: one-hot phase. St0=0001 (NS red), St1=0010 (NS green), St2=0100 (NS yellow), St3=1000 (all-red/walk).
- `Lamp_NS` out 3: {R,Y,G}.
- `Lamp_EW` out 3: {R,Y,G}.
- `Walk` out 1: pedestrian walk lamp.

## Operation
- Phase order: St1 → St2 → St0 → St3 → St1.
- Timer load values per phase: St1=54, St2=4, St0=59, St3=0.
- **Transitions:**
  - St1, St2, St0: advance on `Done_NS`=1.
  - St3 without walk: advance on `Done_NS`.
  - St3 with walk: ignore `Done_NS` and advance on the `WALK_TICKS`-th `En` pulse counted in St3.
- **`State` and `Ld` timing:** `State` is registered. On every transition, `Ld`=1 for exactly the first cycle of the new state; `Ld`=0 otherwise.
- **Tick generator:**
  - Counts 0..`TICK_DIV`-1.
  - `En` = (count==`TICK_DIV`-1) and not `Ld`.
  - The count is forced to 0 during the `Ld` cycle, so every phase starts with a full tick period.
- **Pedestrian request:**
  - `Ped_req`=1 in any cycle sets `ped_lat`.
  - On the St0→St3 transition, `ped_lat` is copied into `walk_act` and `ped_lat` is cleared in the same cycle.
  - A `Ped_req` arriving in that same cycle sets `ped_lat` again and is served on the next cycle.
  - `walk_act` clears on the St3→St1 transition.
- **Walk counter:** width ⌈log2(`WALK_TICKS`+1)⌉. Cleared on entry to St3; increments on `En` while `walk_act`=1.
- **Lamp decode** (combinational from registers and `Q_NS`):
  - St1: NS=001, EW=100.
  - St2: NS=010, EW=100.
  - St0: NS=100, EW=001 if `Q_NS` > `EW_YEL`, else EW=010.
  - St3: both 100.
  - `Walk` = St3 and `walk_act`.
- **Illegal `State`** (not one-hot): next state is St3, with `Ld` asserted and both lamps red.
- **Timer count after expiry:** the timer wraps to 8'hFF for the one `Ld` cycle after each expiry. This is acceptable; the decode treats it as "> `EW_YEL`".

## Timing
- **Reset values:** `State`=St1, `Ld`=0, `En`=0, tick count=0, `ped_lat`=0, `walk_act`=0, walk counter=0, `Lamp_NS`=001, `Lamp_EW`=100, `Walk`=0.
- After reset the timer already holds the green value, so no `Ld` is issued.
- Latency from `Done_NS` to the new `State` plus `Ld`: 1 clock.
- Phase length = 1 (`Ld` cycle) + ticks × `TICK_DIV` clocks. Ticks per phase: St1 55, St2 5, St0 60, St3 1 (or `WALK_TICKS` when walking).
- The first St1 after reset lasts 55 × `TICK_DIV` clocks (no `Ld` cycle).
- `Reset_n` asserted mid-phase returns all outputs to their reset values immediately, without waiting for a clock edge.
- If `Done_NS` and `Ped_req` occur in the same cycle, both are acted on: the transition happens and the request is latched.

## Structure
- Shared package `traf_pkg`:
  - State encodings St0..St3.
  - Lamp codes RED=100, YEL=010, GRN=001.
  - Timer load constants 59/54/4/0.
- One sub-module, `tick_gen` (parameter `TICK_DIV`; inputs `Clk`, `Reset_n`, `Clr`; output `Tick`). The parent drives `Clr` from `Ld` and gates `Tick` with not `Ld` to form `En`.

## Test plan
All scenarios run with `TICK_DIV`=4 and a behavioural countdown timer attached.

- **Reset:** hold `Reset_n`=0 → `State`=0010, `Lamp_NS`=001, `Lamp_EW`=100, `Ld`=0, `En`=0, `Walk`=0. Release → first `En` on the 4th clock after release.
- **Full cycle, no request:** St1 lasts 220 clocks; then St2 21, St0 241, St3 5, St1 221. `Ld` pulses once per entry. Total per repeated cycle: 488 clocks.
- **EW yellow:** in St0, `Lamp_EW` changes 001→010 when `Q_NS` reaches 4 and stays 010 for 5 ticks (20 clocks) until the transition to St3.
- **Walk:** pulse `Ped_req` for 1 clock during St1 → St3 lasts 1 + 8×4 = 33 clocks with `Walk`=1 throughout. Next cycle, without a request, St3 lasts 5 clocks.
- **Request on the St0→St3 edge:** `Ped_req` in the same cycle as the St0 `Done_NS` → the current St3 has `Walk`=0, and the following St3 walks.
- **Reset mid-St0:** drop `Reset_n` 100 clocks into St0 → outputs return to reset values immediately. Release → St1 lasts 220 clocks.
